// File: rtl/rr_select_arbiter_pkg.sv
// rtl/rr_select_arbiter_pkg.sv - shared types, widths and helpers for the round-robin select arbiter
package rr_select_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_state_t;

    localparam int BEAT_W = 4;

    // Select width for n requesters; a single requester pair still needs one bit.
    function automatic int rr_sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_select_arbiter_if.sv
// rtl/rr_select_arbiter_if.sv - request/handshake/select bundle between requesters, arbiter and consumer
interface rr_select_arbiter_if #(
    parameter int N  = 3,
    parameter int SW = 2
);
    logic [N-1:0]  req;
    logic          ready;
    logic [SW-1:0] sb;
    logic [N-1:0]  gnt;
    logic          valid;
    logic [3:0]    beat_cnt;

    modport master (
        input  req,
        input  ready,
        output sb,
        output gnt,
        output valid,
        output beat_cnt
    );

    modport slave (
        output req,
        output ready,
        input  sb,
        input  gnt,
        input  valid,
        input  beat_cnt
    );
endinterface

// File: rtl/rr_select_arbiter_pick.sv
// rtl/rr_select_arbiter_pick.sv - rotating-priority search for the first live request at or after ptr
module rr_pick #(
    parameter int N  = 3,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          found,
    output logic [SW-1:0] idx
);
    int cand;

    // Walk ptr, ptr+1, ... wrapping at N (not 2^SW) and keep the first requester seen.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = SW'(cand);
            end
        end
    end
endmodule

// File: rtl/rr_select_arbiter.sv
// rtl/rr_select_arbiter.sv - fair round-robin arbiter driving the binary select of a 3-input mux with bounded bursts
module rr_select_arbiter
    import rr_select_pkg::*;
#(
    parameter int N     = 3,
    parameter int SW    = rr_sel_w(N),
    parameter int BURST = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_select_arbiter_if.master   bus
);
    rr_state_t          state, state_d;
    logic [SW-1:0]      ptr, ptr_d;
    logic [SW-1:0]      sb_q, sb_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic               valid_q, valid_d;
    logic [BEAT_W-1:0]  cnt_q, cnt_d;

    logic               found;
    logic [SW-1:0]      idx;
    logic               accept;
    logic               last_beat;
    logic               held;

    rr_pick #(.N(N), .SW(SW)) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .found (found),
        .idx   (idx)
    );

    assign accept    = valid_q & bus.ready;
    assign last_beat = accept && (cnt_q == BEAT_W'(BURST - 1));
    // Only the granted requester's line matters; others wait for the next IDLE.
    assign held      = bus.req[sb_q];

    assign bus.sb       = sb_q;
    assign bus.gnt      = gnt_q;
    assign bus.valid    = valid_q;
    assign bus.beat_cnt = cnt_q;

    // Next-state and next-output decode; every register holds unless a transition says otherwise.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        sb_d    = sb_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state)
            IDLE: begin
                if (found) begin
                    sb_d       = idx;
                    gnt_d      = '0;
                    gnt_d[idx] = 1'b1;
                    valid_d    = 1'b1;
                    cnt_d      = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (last_beat || !held) begin
                    // Served requester drops to lowest priority; sb keeps its value for the mux.
                    valid_d = 1'b0;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = (sb_q == SW'(N - 1)) ? '0 : sb_q + SW'(1);
                    state_d = IDLE;
                end else if (accept) begin
                    cnt_d = cnt_q + BEAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset wins over any in-flight burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            sb_q    <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            sb_q    <= sb_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_rr_select_arbiter.sv
// tb/tb_rr_select_arbiter.sv - scoreboard bench for rr_select_arbiter against a behavioural round-robin model
module tb_rr_select_arbiter;
    localparam int N     = 3;
    localparam int SW    = 2;
    localparam int BURST = 2;

    typedef struct {
        int valid;
        int sb;
        int gnt;
        int cnt;
        int ptr;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    exp_t exp_q[$];

    // Behavioural model: who holds the grant (-1 = nobody), beats taken, fairness pointer, last select.
    int m_owner;
    int m_beats;
    int m_ptr;
    int m_sb;

    rr_select_arbiter_if #(.N(N), .SW(SW)) bus ();

    rr_select_arbiter #(.N(N), .SW(SW), .BURST(BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge with the inputs that edge will see.
    task automatic model_edge(input logic r, input logic [N-1:0] rq, input logic rdy);
        exp_t e;
        if (r) begin
            m_owner = -1;
            m_beats = 0;
            m_ptr   = 0;
            m_sb    = 0;
        end else if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                if (m_owner < 0 && rq[(m_ptr + i) % N]) begin
                    m_owner = (m_ptr + i) % N;
                end
            end
            if (m_owner >= 0) begin
                m_sb    = m_owner;
                m_beats = 0;
            end
        end else begin
            if ((rdy && m_beats + 1 == BURST) || !rq[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_beats = 0;
            end else if (rdy) begin
                m_beats = m_beats + 1;
            end
        end
        e.valid = (m_owner >= 0) ? 1 : 0;
        e.sb    = m_sb;
        e.gnt   = (m_owner >= 0) ? (1 << m_owner) : 0;
        e.cnt   = m_beats;
        e.ptr   = m_ptr;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq, input logic rdy);
        @(negedge clk);
        rst       = r;
        bus.req   = rq;
        bus.ready = rdy;
        model_edge(r, rq, rdy);
    endtask

    // Monitor: after each rising edge, compare the DUT against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("valid",    int'(bus.valid),    e.valid);
                check("sb",       int'(bus.sb),       e.sb);
                check("gnt",      int'(bus.gnt),      e.gnt);
                check("beat_cnt", int'(bus.beat_cnt), e.cnt);
                check("ptr",      int'(dut.ptr),      e.ptr);
            end
        end
    end

    initial begin
        tests     = 0;
        fails     = 0;
        m_owner   = -1;
        m_beats   = 0;
        m_ptr     = 0;
        m_sb      = 0;
        rst       = 1'b1;
        bus.req   = '0;
        bus.ready = 1'b0;

        // Reset held with all requests and ready high.
        step(1'b1, 3'b111, 1'b1);
        step(1'b1, 3'b111, 1'b1);
        // Fair rotation under continuous ready.
        for (int i = 0; i < 12; i++) step(1'b0, 3'b111, 1'b1);

        // Backpressure on requester 1.
        step(1'b1, 3'b000, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 3'b010, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 3'b010, 1'b1);
        step(1'b0, 3'b000, 1'b0);

        // Request drop after one beat, then drop while stalled.
        step(1'b1, 3'b000, 1'b0);
        step(1'b0, 3'b001, 1'b0);
        step(1'b0, 3'b001, 1'b1);
        step(1'b0, 3'b000, 1'b0);
        step(1'b0, 3'b001, 1'b0);
        step(1'b0, 3'b001, 1'b0);
        step(1'b0, 3'b000, 1'b0);
        step(1'b0, 3'b000, 1'b0);

        // Wrap: requester 2 then requester 0.
        step(1'b1, 3'b000, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 3'b100, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 3'b001, 1'b1);

        // Reset mid-burst with sb=2, then full requests grant 0 first.
        step(1'b1, 3'b000, 1'b0);
        step(1'b0, 3'b100, 1'b0);
        step(1'b0, 3'b100, 1'b0);
        step(1'b1, 3'b111, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 3'b111, 1'b1);

        // Random traffic with occasional reset.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0));
        end

        step(1'b0, 3'b000, 1'b0);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
